simplesys_pio_in: RTL and testbench
===================================

// Module: simplesys_pio_in
// PURPOSE
//  Avalon-MM slave input port: the read-side companion to the system's output PIO.
//  Samples external lines (keyboard rows/buttons) on in_port, synchronizes and debounces them.
//  Latches selected edges per bit and raises a maskable level interrupt to the Nios II.
//  Sits on the system interconnect next to the output PIO and uses the same slave handshake.
// PARAMETERS
//  WIDTH           8     number of input bits (1..32)
//  DEBOUNCE_CYCLES 0     stable-input cycles required before a change is accepted; 0 = bypass
//  EDGE_TYPE       0     edge that sets edgecapture: 0 = rising, 1 = falling, 2 = any
// PORTS
//  clk         in   1      system clock; all logic on posedge
//  reset       in   1      synchronous, active-high reset
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe, qualified by chipselect
//  writedata   in   32     write data
//  in_port     in   WIDTH  asynchronous external inputs
//  readdata    out  32     read data, zero-extended
//  irq         out  1      level interrupt to CPU
// BEHAVIOUR
//  Register map (zero wait states; readdata is combinational from address, valid in the same cycle):
//   0 DATA     RO  debounced value stable[WIDTH-1:0]; writes ignored
//   1 --       RO  reads 0; writes ignored
//   2 IRQMASK  RW  irqmask <= writedata[WIDTH-1:0]
//   3 EDGECAP  RW1C  a write clears every bit where writedata[i] = 1
//  readdata = {32-WIDTH zeros, mux}. Unselected addresses return 0.
//  readdata does not depend on chipselect; reads have no side effects.
//  Reset (sampled at posedge): s1, s2, stable, stable_d, irqmask, edgecap and counters all go to 0.
//   irq = 0 in the following cycle. A reset mid-debounce discards the pending change.
//  Sync: s1 <= in_port; s2 <= s1. Input at edge 0 appears in s2 after edge 2.
//  Debounce, per bit, DEBOUNCE_CYCLES = D >= 1:
//   - cnt has $clog2(D+1) bits.
//   - if s2 == stable: cnt <= 0.
//   - else if cnt == D-1: stable <= s2, cnt <= 0.
//   - else: cnt <= cnt + 1.
//   - A glitch shorter than D cycles never reaches stable.
//   - Latency from in_port to DATA is 2+D edges.
//  D = 0: stable <= s2 every cycle; latency 3 edges (DATA register always registered).
//  Edge detect: stable_d <= stable.
//   - rise = stable & ~stable_d; fall = ~stable & stable_d.
//   - sel = rise, fall or rise|fall per EDGE_TYPE.
//  edgecap[i] <= (edgecap[i] & ~clr[i]) | sel[i], where clr = writedata if (chipselect & ~write_n & address==3).
//   - A set and a clear of the same bit in the same cycle: set wins.
//   - Sticky until cleared. edgecap is independent of irqmask.
//  irq = |(edgecap & irqmask), combinational from registers.
//   - Unmasking an already captured bit asserts irq in the cycle after the IRQMASK write.
//  writedata bits above WIDTH are ignored. Writes to addresses 0 and 1 have no effect.
// STRUCTURE
//  Package simplesys_pio_pkg:
//   - address constants PIO_ADDR_DATA = 0, PIO_ADDR_IRQMASK = 2, PIO_ADDR_EDGECAP = 3.
//   - edge encodings PIO_EDGE_RISE = 0, PIO_EDGE_FALL = 1, PIO_EDGE_ANY = 2.
//  Sub-module simplesys_pio_debounce:
//   - one bit: s1/s2 sync plus the counter, parameter D.
//   - output stable; WIDTH instances generated.
//  The top level holds stable_d, edgecap, irqmask, the read mux and irq.
// TESTING
//  1 Reset values:
//    - assert reset for 2 cycles with in_port = 8'hFF -> readdata = 0 at all addresses, irq = 0.
//    - DATA reads 8'hFF 3 edges after reset is released (D = 0).
//  2 Debounce, D = 4, in_port[0]:
//    - 3-cycle pulse 0->1->0 -> DATA stays 0, edgecap stays 0.
//    - hold 1 -> DATA[0] = 1 exactly 6 edges after the change.
//  3 Rising capture with mask:
//    - IRQMASK = 8'h01, in_port 8'h00 -> 8'h05 -> EDGECAP = 8'h05, irq = 1.
//    - write EDGECAP 8'h01 -> EDGECAP = 8'h04, irq = 0 next cycle.
//  4 Collision:
//    - write EDGECAP 8'hFF in the same cycle a new rising edge on bit 1 is detected -> EDGECAP = 8'h02 after the write.
//  5 EDGE_TYPE = 2:
//    - in_port[3] toggles 1->0 -> EDGECAP[3] sets.
//    - clear it, then IRQMASK = 0 -> irq stays 0 while the capture re-sets.
//  6 Width/decode:
//    - WIDTH = 5; write IRQMASK 32'hFFFF_FFFF -> read returns 32'h0000_001F.
//    - read address 1 -> 0; write address 0 -> DATA unchanged.

Source files
------------

// File: rtl/simplesys_pio_pkg.sv
// Shared register addresses, edge-select encodings and the edge-select helper
// for the simplesys input PIO.
package simplesys_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int unsigned PIO_EDGE_RISE = 0;
    localparam int unsigned PIO_EDGE_FALL = 1;
    localparam int unsigned PIO_EDGE_ANY  = 2;

    function automatic logic [31:0] pio_edge_sel(input logic [31:0] rise,
                                                 input logic [31:0] fall,
                                                 input int unsigned edge_type);
        logic [31:0] sel;
        sel = '0;
        case (edge_type)
            PIO_EDGE_RISE: sel = rise;
            PIO_EDGE_FALL: sel = fall;
            default:       sel = rise | fall;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/simplesys_pio_debounce.sv
// One input bit: two-flop synchronizer followed by a stability counter that
// only accepts a new level after D consecutive differing samples (D = 0 bypasses).
module simplesys_pio_debounce #(
    parameter int unsigned D = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    if (D == 0) begin : g_bypass
        always_ff @(posedge clk) begin
            if (reset) stable <= 1'b0;
            else       stable <= s2;
        end
    end else begin : g_count
        localparam int unsigned CW = $clog2(D + 1);
        logic [CW-1:0] cnt;

        // Counter restarts whenever the synchronized input agrees with stable,
        // so any excursion shorter than D samples is discarded.
        always_ff @(posedge clk) begin
            if (reset) begin
                stable <= 1'b0;
                cnt    <= '0;
            end else if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(D - 1)) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/simplesys_pio_in.sv
// Avalon-MM input PIO: debounced DATA, per-bit edge capture (RW1C) and a
// maskable level interrupt; zero-wait-state combinational read mux.
module simplesys_pio_in
    import simplesys_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] clr;
    logic             wr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        simplesys_pio_debounce #(
            .D(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (in_port[i]),
            .stable(stable[i])
        );
    end

    assign wr  = chipselect & ~write_n;
    assign sel = WIDTH'(pio_edge_sel(32'(stable & ~stable_d),
                                     32'(~stable & stable_d), EDGE_TYPE));
    assign clr = (wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Writedata bits at and above WIDTH are intentionally ignored.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
            irqmask  <= '0;
            edgecap  <= '0;
        end else begin
            stable_d <= stable;
            if (wr && address == PIO_ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
            // Set is OR-ed after the clear so a same-cycle edge survives the write.
            edgecap <= (edgecap & ~clr) | sel;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = stable;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
            default:          readdata = '0;
        endcase
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_simplesys_pio_in.sv
// Bench for simplesys_pio_in: four parameter variants share one bus and are
// compared every cycle against a behavioural model, plus directed scenarios.
module tb_simplesys_pio_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd [4];
    logic        irqv [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    simplesys_pio_in #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_d0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irqv[0]));
    simplesys_pio_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_d4 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irqv[1]));
    simplesys_pio_in #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irqv[2]));
    simplesys_pio_in #(.WIDTH(5), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(1)) u_w5 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port[4:0]),
        .readdata(rd[3]), .irq(irqv[3]));

    // Per-instance configuration, mirrored from the instantiations above.
    function automatic logic [31:0] wmask(input int k);
        return (k == 3) ? 32'h0000_001F : 32'h0000_00FF;
    endfunction
    function automatic int dcyc(input int k);
        case (k)
            1:       return 4;
            3:       return 2;
            default: return 0;
        endcase
    endfunction
    function automatic int etype(input int k);
        case (k)
            2:       return 2;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    // Model: "stable" takes a bit's synchronized value once the last D samples
    // seen all disagreed with it; edges compare consecutive stable values.
    logic [31:0] m_s1 [4] = '{default: '0};
    logic [31:0] m_s2 [4] = '{default: '0};
    logic [31:0] m_st [4] = '{default: '0};
    logic [31:0] m_std [4] = '{default: '0};
    logic [31:0] m_mask [4] = '{default: '0};
    logic [31:0] m_cap [4] = '{default: '0};
    logic [31:0] m_win [4][8];
    int          m_n [4] = '{default: 0};

    task automatic model_step(input int k);
        logic [31:0] msk, rise, fall, sel, clr, nst, ncap;
        int          d;
        bit          diff;
        msk = wmask(k);
        d   = dcyc(k);
        if (reset) begin
            m_s1[k] = '0; m_s2[k] = '0; m_st[k] = '0; m_std[k] = '0;
            m_mask[k] = '0; m_cap[k] = '0; m_n[k] = 0;
        end else begin
            rise = m_st[k] & ~m_std[k];
            fall = ~m_st[k] & m_std[k];
            case (etype(k))
                0:       sel = rise;
                1:       sel = fall;
                default: sel = rise | fall;
            endcase
            clr  = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
            ncap = ((m_cap[k] & ~clr) | sel) & msk;
            if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata & msk;
            nst = m_st[k];
            if (d == 0) begin
                nst = m_s2[k];
            end else begin
                if (m_n[k] == d) begin
                    for (int i = 0; i < d - 1; i++) m_win[k][i] = m_win[k][i+1];
                    m_win[k][d-1] = m_s2[k];
                end else begin
                    m_win[k][m_n[k]] = m_s2[k];
                    m_n[k]++;
                end
                if (m_n[k] == d) begin
                    for (int j = 0; j < 32; j++) begin
                        diff = 1'b1;
                        for (int i = 0; i < d; i++)
                            if (m_win[k][i][j] == m_st[k][j]) diff = 1'b0;
                        if (diff) nst[j] = m_s2[k][j];
                    end
                end
            end
            m_std[k] = m_st[k];
            m_st[k]  = nst;
            m_s2[k]  = m_s1[k];
            m_s1[k]  = {24'h0, in_port} & msk;
            m_cap[k] = ncap;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) model_step(k);
    end

    function automatic logic [31:0] exp_rd(input int k);
        case (address)
            2'd0:    return m_st[k];
            2'd2:    return m_mask[k];
            2'd3:    return m_cap[k];
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("model_rd%0d_a%0d", k, address), rd[k], exp_rd(k));
            chk($sformatf("model_irq%0d", k), 32'(irqv[k]), 32'(|(m_cap[k] & m_mask[k])));
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    task automatic peek(input logic [1:0] a);
        address = a;
        #1;
        compare_all();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 8'hFF;

        // Reset: all addresses read zero, no interrupt.
        tick(2);
        for (int a = 0; a < 4; a++) begin
            peek(2'(a));
            chk($sformatf("reset_rd_a%0d", a), rd[0], 32'h0);
        end
        chk("reset_irq", 32'(irqv[0]), 32'h0);

        // Reset release: D=0 shows FF after 3 edges, D=4 after 6.
        reset = 1'b0;
        peek(2'd0);
        tick(2);
        chk("d0_data_edge2", rd[0], 32'h0);
        tick();
        chk("d0_data_edge3", rd[0], 32'hFF);
        tick(2);
        chk("d4_data_edge5", rd[1], 32'h0);
        tick();
        chk("d4_data_edge6", rd[1], 32'hFF);

        // Debounce D=4: a 3-cycle pulse is rejected, a held level lands at 2+D.
        in_port = 8'h00;
        tick(10);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h01;
        tick(3);
        in_port = 8'h00;
        tick(10);
        peek(2'd0);
        chk("d4_glitch_data", rd[1], 32'h0);
        peek(2'd3);
        chk("d4_glitch_cap", rd[1], 32'h0);
        peek(2'd0);
        in_port = 8'h01;
        tick(5);
        chk("d4_hold_edge5", rd[1], 32'h0);
        tick();
        chk("d4_hold_edge6", rd[1], 32'h01);

        // Rising capture with mask.
        bus_write(2'd2, 32'h01);
        in_port = 8'h00;
        tick(5);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h05;
        tick(5);
        peek(2'd3);
        chk("rise_cap", rd[0], 32'h05);
        chk("rise_irq", 32'(irqv[0]), 32'h1);
        bus_write(2'd3, 32'h01);
        peek(2'd3);
        chk("w1c_cap", rd[0], 32'h04);
        chk("w1c_irq", 32'(irqv[0]), 32'h0);

        // Clear-all write coinciding with a new rising edge on bit 1.
        in_port = 8'h07;
        tick(3);
        bus_write(2'd3, 32'hFF);
        peek(2'd3);
        chk("collision_cap", rd[0], 32'h02);

        // Any-edge instance: a falling edge on bit 3 captures; masked irq stays low.
        in_port = 8'h0F;
        tick(5);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h07;
        tick(4);
        peek(2'd3);
        chk("any_fall_cap", rd[2], 32'h08);
        bus_write(2'd3, 32'h08);
        bus_write(2'd2, 32'h00);
        in_port = 8'h0F;
        tick(4);
        peek(2'd3);
        chk("any_rise_cap", rd[2], 32'h08);
        chk("any_masked_irq", 32'(irqv[2]), 32'h0);

        // Width-5 instance: mask truncation, hole address, ignored DATA write.
        bus_write(2'd2, 32'hFFFF_FFFF);
        peek(2'd2);
        chk("w5_mask", rd[3], 32'h0000_001F);
        peek(2'd1);
        chk("w5_hole", rd[3], 32'h0);
        tick(4);
        peek(2'd0);
        chk("w5_data", rd[3], 32'h0F);
        bus_write(2'd0, 32'hAA);
        peek(2'd0);
        chk("w5_data_after_write", rd[3], 32'h0F);

        // Randomized traffic: slowly wandering inputs, random bus activity, rare resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 40) == 0) in_port = 8'($urandom);
            reset      = ($urandom_range(0, 149) == 0);
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
